load_store_unit: RTL and testbench

//  Sits between the execute stage (ALU address/store data) and data_memory.
//  - Turns byte-addressed load/store requests into word-indexed data_memory accesses.
//  - Stores: byte/half stores use read-modify-write; word stores write directly.
//  - Loads: byte/half results are sign- or zero-extended.
//  - Upstream: one request at a time, valid/ready handshake.

---
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit
//   Bridges the execute stage to a word-organised data_memory. Byte-addressed
//   loads/stores become word-indexed accesses; byte/half stores do a
//   read-modify-write, word stores write straight through; byte/half loads are
//   sign- or zero-extended. One request in flight, valid/ready upstream.
//
// Parameters
//   MEM_WORDS   data_memory depth in words (power of 2), word index wraps
//   BIG_ENDIAN  0: byte k at bits[8k+7:8k]; 1: byte k at bits[31-8k:24-8k]
//
// Configuration macro
//   LSU_MISALIGN_TRAP_EN  defined: misaligned half/word requests skip memory
//                         and respond after one cycle with RespFault=1.
//                         undefined: misaligned low bits are ignored and
//                         RespFault is tied 0.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ReqValid/ReqReady        request handshake
//   ReqWrite/ReqSize/ReqSigned/ReqAddr/ReqWData   request fields
//   RespValid/RespRData/RespFault                 one-cycle response
//   MemAddress/MemWriteData/MemWrite/MemReadData  data_memory side
module load_store_unit #(
  parameter int MEM_WORDS  = 256,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        RespFault,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  state_t state, nextState;

  logic        wrQ, signedQ, faultQ;
  logic [1:0]  sizeQ, lowQ;
  logic [31:0] wdataQ, holdQ;

  logic        accept, reqMis;
  logic [4:0]  byteSh, halfSh;
  logic [31:0] laneMask, laneData, mergedWord, loadData;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  assign accept = ReqValid && ReqReady;

  always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
    reqMis = (ReqSize == 2'b01 && ReqAddr[0]) || (ReqSize[1] && ReqAddr[1:0] != 2'b00);
`else
    reqMis = 1'b0;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) begin
                 if (reqMis)                      nextState = RESP;
                 else if (ReqWrite && ReqSize[1]) nextState = WRITE;
                 else                             nextState = READ;
               end
      READ:    nextState = wrQ ? WRITE : RESP;
      WRITE:   nextState = RESP;
      default: nextState = IDLE;
    endcase
  end

  // Request latch and read holding register; MemAddress is the latched word index
  always_ff @(posedge clk) begin
    if (rst) begin
      wrQ        <= 1'b0;
      sizeQ      <= 2'b00;
      signedQ    <= 1'b0;
      lowQ       <= 2'b00;
      wdataQ     <= '0;
      holdQ      <= '0;
      faultQ     <= 1'b0;
      MemAddress <= '0;
    end else begin
      if (accept) begin
        wrQ        <= ReqWrite;
        sizeQ      <= ReqSize;
        signedQ    <= ReqSigned;
        lowQ       <= ReqAddr[1:0];
        wdataQ     <= ReqWData;
        faultQ     <= reqMis;
        MemAddress <= {2'b00, ReqAddr[31:2]} & ADDR_MASK;
      end
      if (state == READ) holdQ <= MemReadData;
    end
  end

  // Lane positions: big-endian mirrors the byte index (8*(3-k) == 8*~k)
  assign byteSh = BIG_ENDIAN ? {~lowQ, 3'b000}   : {lowQ, 3'b000};
  assign halfSh = BIG_ENDIAN ? {~lowQ[1], 4'b0000} : {lowQ[1], 4'b0000};

  // sizeQ[0] distinguishes half from byte whenever the access is not a word
  assign laneMask   = sizeQ[0] ? (32'h0000_FFFF << halfSh) : (32'h0000_00FF << byteSh);
  assign laneData   = sizeQ[0] ? (wdataQ << halfSh)        : (wdataQ << byteSh);
  assign mergedWord = (holdQ & ~laneMask) | (laneData & laneMask);

  assign ldByte = 8'(holdQ >> byteSh);
  assign ldHalf = 16'(holdQ >> halfSh);

  always_comb begin
    if (sizeQ[1])      loadData = holdQ;
    else if (sizeQ[0]) loadData = {{16{signedQ & ldHalf[15]}}, ldHalf};
    else               loadData = {{24{signedQ & ldByte[7]}}, ldByte};
  end

  // Outputs; rst gates the strobes so a reset cycle never writes or responds
  always_comb begin
    ReqReady     = (state == IDLE) && !rst;
    MemWrite     = (state == WRITE) && !rst;
    MemWriteData = '0;
    if (state == WRITE) MemWriteData = sizeQ[1] ? wdataQ : mergedWord;
    RespValid    = (state == RESP) && !rst;
    RespRData    = '0;
    if (RespValid && !wrQ && !faultQ) RespRData = loadData;
`ifdef LSU_MISALIGN_TRAP_EN
    RespFault    = RespValid && faultQ;
`else
    RespFault    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        ReqValid, ReqReady, ReqWrite, ReqSigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqWData;
  logic        RespValid, RespFault, MemWrite;
  logic [31:0] RespRData, MemAddress, MemWriteData, MemReadData;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
    .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespRData(RespRData), .RespFault(RespFault),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
    .MemReadData(MemReadData)
  );

  always #5 clk = ~clk;

  // data_memory stand-in, with a bench-only preload port
  logic [31:0] mem [256];
  logic        plEn;
  logic [7:0]  plIdx;
  logic [31:0] plData;
  assign MemReadData = mem[MemAddress[7:0]];
  always @(posedge clk) begin
    if (plEn)          mem[plIdx] <= plData;
    else if (MemWrite) mem[MemAddress[7:0]] <= MemWriteData;
  end

  // Reference model: memory as a flat little-endian byte array
  logic [7:0] refBytes [1024];
  int nAssert = 0, nFail = 0;
  logic [31:0] lastRData, lastIdx;

  function automatic logic [31:0] refWord(int i);
    return {refBytes[i*4+3], refBytes[i*4+2], refBytes[i*4+1], refBytes[i*4]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic setWord(int i, logic [31:0] w);
    @(negedge clk);
    plEn = 1'b1; plIdx = 8'(i); plData = w;
    for (int k = 0; k < 4; k++) refBytes[i*4+k] = w[8*k +: 8];
    @(negedge clk);
    plEn = 1'b0;
  endtask

  task automatic doReq(logic w, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd);
    int idx, nb, first, expLat, expMw, lat, mw;
    bit mis, got;
    logic [31:0] val, expData;
    idx   = int'((a >> 2) % 32'd256);
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis   = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
`endif
    nb    = sz[1] ? 4 : (sz[0] ? 2 : 1);
    first = sz[1] ? 0 : (sz[0] ? 2 * int'(a[1]) : int'(a[1:0]));
    val   = '0;
    for (int j = 0; j < nb; j++) val = val | (32'(refBytes[idx*4+first+j]) << (8*j));
    if (sg && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
    expData = (w || mis) ? 32'd0 : val;
    expLat  = mis ? 1 : ((w && nb < 4) ? 3 : 2);
    expMw   = (w && !mis) ? 1 : 0;
    if (w && !mis)
      for (int j = 0; j < nb; j++) refBytes[idx*4+first+j] = wd[8*j +: 8];

    @(negedge clk);
    chk("respIdle", 32'(RespValid), 32'd0);
    chk("readyIdle", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    lat = 0; mw = 0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        ReqValid = 1'b0;
        lastIdx = MemAddress;
        if (!mis) chk("memAddr", MemAddress, 32'(idx));
      end
      if (MemWrite) mw++;
      if (RespValid) begin
        got = 1'b1;
        lastRData = RespRData;
        chk("rdata", RespRData, expData);
        chk("fault", 32'(RespFault), 32'(mis));
      end
    end
    chk("respSeen", 32'(got), 32'd1);
    chk("latency", 32'(lat), 32'(expLat));
    chk("memWriteCycles", 32'(mw), 32'(expMw));
    if (w && !mis) chk("memWord", mem[idx], refWord(idx));
  endtask

  initial begin
    rst = 1'b1; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqSigned = 1'b0;
    ReqAddr = '0; ReqWData = '0; plEn = 1'b0; plIdx = '0; plData = '0;
    lastRData = '0; lastIdx = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rstReady", 32'(ReqReady), 32'd0);
    chk("rstRespValid", 32'(RespValid), 32'd0);
    chk("rstRData", RespRData, 32'd0);
    chk("rstFault", 32'(RespFault), 32'd0);
    chk("rstMemWrite", 32'(MemWrite), 32'd0);
    chk("rstMemWData", MemWriteData, 32'd0);
    chk("rstMemAddr", MemAddress, 32'd0);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      plEn = 1'b1; plIdx = 8'(i); plData = $urandom;
      for (int k = 0; k < 4; k++) refBytes[i*4+k] = plData[8*k +: 8];
    end
    @(negedge clk);
    plEn = 1'b0;

    // Requests during reset are ignored
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqAddr = 32'h10; ReqWData = 32'hDEAD_BEEF;
    repeat (3) begin
      @(negedge clk);
      chk("rstNoWrite", 32'(MemWrite), 32'd0);
      chk("rstNoResp", 32'(RespValid), 32'd0);
    end
    ReqValid = 1'b0;
    rst = 1'b0;
    #1 chk("readyAfterRst", 32'(ReqReady), 32'd1);
    @(negedge clk);
    chk("rstReqDropped", mem[4], refWord(4));

    // 1: signed / unsigned byte load
    setWord(2, 32'h1234_80FF);
    doReq(1'b0, 2'b00, 1'b1, 32'h09, 32'h0);
    chk("t1Signed", lastRData, 32'hFFFF_FF80);
    doReq(1'b0, 2'b00, 1'b0, 32'h09, 32'h0);
    chk("t1Unsigned", lastRData, 32'h0000_0080);

    // 2: half store read-modify-write
    setWord(3, 32'hAABB_CCDD);
    doReq(1'b1, 2'b01, 1'b0, 32'h0E, 32'h0000_1234);
    chk("t2Merged", mem[3], 32'h1234_CCDD);

    // 3: word store then load back; size 11 load too
    doReq(1'b1, 2'b10, 1'b0, 32'h20, 32'd20);
    chk("t3Stored", mem[8], 32'd20);
    doReq(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("t3Load", lastRData, 32'd20);
    doReq(1'b0, 2'b11, 1'b1, 32'h20, 32'h0);
    chk("t3Size11", lastRData, 32'd20);

    // 4: reset during WRITE of a byte store to mem[1]
    setWord(1, 32'h1122_3344);
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b00; ReqAddr = 32'h05; ReqWData = 32'hAA;
    @(negedge clk);
    ReqValid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("t4MemWriteGated", 32'(MemWrite), 32'd0);
    chk("t4NoResp", 32'(RespValid), 32'd0);
    @(negedge clk);
    chk("t4NoResp2", 32'(RespValid), 32'd0);
    chk("t4ReadyInRst", 32'(ReqReady), 32'd0);
    rst = 1'b0;
    #1 chk("t4ReadyAfter", 32'(ReqReady), 32'd1);
    @(negedge clk);
    chk("t4NoResp3", 32'(RespValid), 32'd0);
    chk("t4MemKept", mem[1], 32'h1122_3344);

    // 5: misaligned word load at 0x06
    doReq(1'b0, 2'b10, 1'b0, 32'h06, 32'h0);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("t5Aligned", lastRData, 32'h1122_3344);
`endif

    // 6: held valid across two loads
    setWord(5, 32'hCAFE_0005);
    setWord(6, 32'hBEEF_0006);
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'b10; ReqAddr = 32'h14;
    @(negedge clk);
    chk("b2bBusy1", 32'(ReqReady), 32'd0);
    ReqAddr = 32'h18;
    @(negedge clk);
    chk("b2bResp1", 32'(RespValid), 32'd1);
    chk("b2bData1", RespRData, 32'hCAFE_0005);
    chk("b2bBusy2", 32'(ReqReady), 32'd0);
    @(negedge clk);
    chk("b2bReady", 32'(ReqReady), 32'd1);
    chk("b2bGap", 32'(RespValid), 32'd0);
    @(negedge clk);
    ReqValid = 1'b0;
    chk("b2bBusy3", 32'(ReqReady), 32'd0);
    @(negedge clk);
    chk("b2bResp2", 32'(RespValid), 32'd1);
    chk("b2bData2", RespRData, 32'hBEEF_0006);

    // Address wrap
    doReq(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    chk("wrapIdx", lastIdx, 32'd0);

    // Random traffic against the byte-array model
    for (int n = 0; n < 80; n++)
      doReq(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
